mux_tree_pipe: RTL and testbench

- Parametrised, pipelined N:1 word multiplexer for the ALU result path.
- Successor to the fixed 8:1 combinational tree. Generalises word width and input count, and adds pipeline registers every REG_EVERY tree levels.
- Valid/ready handshake with backpressure, so the ALU result select can run at full clock rate for wide operand sets.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/mux2_param.sv | 13 +
 rtl/mux_tree_pipe.sv | 138 +++++++++++++
 tb/tb_mux_tree_pipe.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result-path multiplexer: tree geometry
// helpers and the reset constant for data registers.
package alu_pkg;

   // Value every data bit takes while rst_n is low.
   localparam logic RST_BIT = 1'b0;

   // Number of 2:1 tree levels needed to reduce num_inputs words to one.
   function automatic int mux_levels(input int num_inputs);
      int lv;
      lv = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < num_inputs) lv = i + 1;
      end
      return lv;
   endfunction

   // Number of register stages when each stage absorbs reg_every levels.
   function automatic int mux_stages(input int levels, input int reg_every);
      return (levels + reg_every - 1) / reg_every;
   endfunction

   // True for powers of two that are at least 2.
   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/mux2_param.sv
// One tree node: a WIDTH-bit 2:1 multiplexer, y = s ? b : a.
module mux2_param #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] y
);

   assign y = s ? b : a;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined NUM_INPUTS:1 word multiplexer. The binary select is consumed
// one bit per tree level (LSB first); a register stage closes every
// REG_EVERY levels and carries partial words, remaining select bits and a
// valid flag. Stages use a valid/ready handshake so the pipe compacts and
// streams one beat per cycle.
module mux_tree_pipe
   import alu_pkg::*;
#(
   parameter  int WIDTH      = 32,
   parameter  int NUM_INPUTS = 8,
   parameter  int REG_EVERY  = 1,
   localparam int LEVELS     = mux_levels(NUM_INPUTS),
   localparam int STAGES     = mux_stages(LEVELS, REG_EVERY),
   localparam int SEL_W      = (LEVELS > 0) ? LEVELS : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
   input  logic [SEL_W-1:0]            in_sel,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic [WIDTH-1:0]            out_data,
   output logic                        out_valid,
   input  logic                        out_ready
);

   // Reject geometries the tree cannot be built for.
   if (!is_pow2(NUM_INPUTS)) begin : g_bad_inputs
      $error("mux_tree_pipe: NUM_INPUTS=%0d must be a power of two >= 2", NUM_INPUTS);
   end
   if ((REG_EVERY < 1) || (REG_EVERY > LEVELS)) begin : g_bad_reg_every
      $error("mux_tree_pipe: REG_EVERY=%0d must be in 1..%0d", REG_EVERY, LEVELS);
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("mux_tree_pipe: WIDTH=%0d must be >= 1", WIDTH);
   end

   logic [STAGES-1:0] stage_valid;
   logic [STAGES:0]   stage_ready;

   // Ready ripples back from the sink: a stage can load when it is empty
   // or when the stage after it is taking its current beat.
   always_comb begin
      // NOTE: assign every always_comb output up front so no path leaves it unassigned (no latch).
      stage_ready         = '0;
      stage_ready[STAGES] = out_ready;
      for (int s = STAGES - 1; s >= 0; s--) begin
         stage_ready[s] = !stage_valid[s] || stage_ready[s+1];
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int L_LO    = s * REG_EVERY;
      localparam int L_HI    = ((s + 1) * REG_EVERY < LEVELS) ? (s + 1) * REG_EVERY : LEVELS;
      localparam int N_LVL   = L_HI - L_LO;
      localparam int W_IN    = NUM_INPUTS >> L_LO;
      localparam int W_OUT   = NUM_INPUTS >> L_HI;
      localparam int SEL_IN  = LEVELS - L_LO;
      localparam int SEL_OUT = LEVELS - L_HI;

      logic [W_IN*WIDTH-1:0]  src_data;
      logic [SEL_IN-1:0]      src_sel;
      logic                   src_valid;
      logic [W_OUT*WIDTH-1:0] data_d;
      logic [W_OUT*WIDTH-1:0] data_q;
      logic                   valid_q;

      if (s == 0) begin : g_src_port
         assign src_data  = in_data;
         assign src_sel   = in_sel;
         assign src_valid = in_valid;
      end else begin : g_src_reg
         assign src_data  = g_stage[s-1].data_q;
         assign src_sel   = g_stage[s-1].g_sel.sel_q;
         assign src_valid = g_stage[s-1].valid_q;
      end

      // Tree levels inside this stage; bit l of src_sel steers level L_LO+l.
      for (genvar l = 0; l < N_LVL; l++) begin : g_lvl
         localparam int N_NODE = W_IN >> (l + 1);

         logic [2*N_NODE*WIDTH-1:0] lvl_in;
         logic [N_NODE*WIDTH-1:0]   lvl_out;

         if (l == 0) begin : g_first
            assign lvl_in = src_data;
         end else begin : g_next
            assign lvl_in = g_lvl[l-1].lvl_out;
         end

         for (genvar k = 0; k < N_NODE; k++) begin : g_node
            mux2_param #(
               .WIDTH (WIDTH)
            ) u_mux (
               .a (lvl_in[(2*k)*WIDTH +: WIDTH]),
               .b (lvl_in[(2*k+1)*WIDTH +: WIDTH]),
               .s (src_sel[l]),
               .y (lvl_out[k*WIDTH +: WIDTH])
            );
         end
      end

      assign data_d         = g_lvl[N_LVL-1].lvl_out;
      assign stage_valid[s] = valid_q;

      // Stage register: load the reduced words and upstream valid when
      // ready, otherwise hold; synchronous clear on reset.
      always_ff @(posedge clk) begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {(W_OUT*WIDTH){RST_BIT}};
         end else if (stage_ready[s]) begin
            valid_q <= src_valid;
            data_q  <= data_d;
         end
      end

      // Select bits not yet consumed travel with the partial words.
      if (SEL_OUT > 0) begin : g_sel
         logic [SEL_OUT-1:0] sel_q;

         // Carry the upper select bits alongside the data register.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               sel_q <= '0;
            end else if (stage_ready[s]) begin
               sel_q <= src_sel[SEL_IN-1:N_LVL];
            end
         end
      end
   end

   assign in_ready  = stage_ready[0];
   assign out_valid = stage_valid[STAGES-1];
   assign out_data  = g_stage[STAGES-1].data_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench for mux_tree_pipe. Four configurations run side by side;
// each has a driver that pushes the expected word into a queue as a beat is
// accepted and a monitor that pops and compares whenever a beat leaves.
module tb_mux_tree_pipe;

   typedef struct {
      logic [31:0] data;
      int          cyc;
      bit          lat;
   } exp_t;

   logic clk;
   int   cyc;
   int   errors;
   int   checks;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      errors = 0;
      checks = 0;
   end

   task automatic check(input int cfg, input string name, input bit ok,
                        input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL cfg%0d %s: got %h, want %h (cycle %0d)", cfg, name, act, req, cyc);
      end
   endtask

   // cfg0: W32 N8 RE1 (LAT3); cfg1: W32 N8 RE3 (LAT1);
   // cfg2: W32 N16 RE3 (LAT2); cfg3: W1 N2 RE1 (LAT1).
   for (genvar c = 0; c < 4; c++) begin : g_cfg
      localparam int W   = (c == 3) ? 1 : 32;
      localparam int N   = (c == 2) ? 16 : ((c == 3) ? 2 : 8);
      localparam int RE  = (c == 1 || c == 2) ? 3 : 1;
      localparam int LAT = (c == 0) ? 3 : ((c == 2) ? 2 : 1);
      localparam int SW  = (c == 2) ? 4 : ((c == 3) ? 1 : 3);

      logic          rst_n;
      logic [N*W-1:0] in_data;
      logic [SW-1:0] in_sel;
      logic          in_valid;
      logic          in_ready;
      logic [W-1:0]  out_data;
      logic          out_valid;
      logic          out_ready;
      exp_t          q[$];
      logic          stall_prev;
      bit            done;

      mux_tree_pipe #(
         .WIDTH      (W),
         .NUM_INPUTS (N),
         .REG_EVERY  (RE)
      ) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_data   (in_data),
         .in_sel    (in_sel),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .out_data  (out_data),
         .out_valid (out_valid),
         .out_ready (out_ready)
      );

      // Monitor: compare the head of the queue whenever a beat is offered.
      initial stall_prev = 1'b0;
      always @(negedge clk) begin
         if (!rst_n) begin
            stall_prev <= 1'b0;
         end else begin
            if (stall_prev) check(c, "hold_valid", out_valid, 32'(out_valid), 32'd1);
            if (out_valid) begin
               check(c, "beat_expected", q.size() != 0, 32'(out_data), 32'(q.size()));
               if (q.size() != 0) begin
                  check(c, "data", 32'(out_data) == q[0].data, 32'(out_data), q[0].data);
                  if (q[0].lat && !stall_prev)
                     check(c, "latency", cyc == q[0].cyc, 32'(cyc), 32'(q[0].cyc));
                  if (out_ready) void'(q.pop_front());
               end
            end
            stall_prev <= out_valid && !out_ready;
         end
      end

      task automatic step();
         @(posedge clk);
         #1;
      endtask

      task automatic present(input int sel, input logic [31:0] base);
         in_valid = 1'b1;
         in_sel   = SW'(sel);
         for (int k = 0; k < N; k++) in_data[k*W +: W] = W'(base + 32'(k));
      endtask

      // Called just after a rising edge; returns on the falling edge before
      // the accepting edge, with the number of cycles spent waiting.
      task automatic send(input int sel, input logic [31:0] base, input bit lat,
                          output int waits);
         logic [W-1:0] wv;
         exp_t         e;
         present(sel, base);
         waits = 0;
         @(negedge clk);
         while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
         end
         if (in_ready) begin
            wv     = W'(base + 32'(sel));
            e.data = 32'(wv);
            e.cyc  = cyc + LAT;
            e.lat  = lat;
            q.push_back(e);
         end else begin
            check(c, "accept_timeout", in_ready, 32'(in_ready), 32'd1);
         end
      endtask

      task automatic drain();
         int n;
         n = 0;
         while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
         end
         @(negedge clk);
         check(c, "drain", q.size() == 0, 32'(q.size()), 32'd0);
      endtask

      initial begin
         int w;
         done      = 1'b0;
         rst_n     = 1'b0;
         in_valid  = 1'b0;
         in_sel    = '0;
         in_data   = '0;
         out_ready = 1'b1;
         repeat (3) @(posedge clk);
         #1;
         rst_n = 1'b1;
         @(negedge clk);
         check(c, "reset_out_valid", !out_valid, 32'(out_valid), 32'd0);
         check(c, "reset_out_data", out_data == '0, 32'(out_data), 32'd0);
         check(c, "reset_in_ready", in_ready, 32'(in_ready), 32'd1);

         // Single isolated beats over every select value.
         step();
         for (int s = 0; s < N; s++) begin
            send(s, 32'hA000_0000, 1'b1, w);
            step();
            in_valid = 1'b0;
            repeat (LAT + 1) step();
         end
         drain();

         // Back-to-back stream, descending select.
         step();
         for (int i = 0; i < N; i++) begin
            send(N - 1 - i, 32'hB000_0000, 1'b1, w);
            check(c, "stream_ready", w == 0, 32'(w), 32'd0);
            step();
         end
         in_valid = 1'b0;
         drain();

         // Backpressure: fill every stage, hold, then push and pop together.
         step();
         out_ready = 1'b0;
         for (int i = 0; i < LAT; i++) begin
            send(i % N, 32'hC000_0000, 1'b0, w);
            step();
         end
         present(LAT % N, 32'hC000_0000);
         @(negedge clk);
         check(c, "full_in_ready", !in_ready, 32'(in_ready), 32'd0);
         check(c, "full_out_valid", out_valid, 32'(out_valid), 32'd1);
         repeat (2) begin
            step();
            @(negedge clk);
            check(c, "stall_in_ready", !in_ready, 32'(in_ready), 32'd0);
         end
         step();
         out_ready = 1'b1;
         send(LAT % N, 32'hC000_0000, 1'b0, w);
         check(c, "simult_in_ready", w == 0, 32'(w), 32'd0);
         check(c, "simult_out_valid", out_valid, 32'(out_valid), 32'd1);
         for (int i = 0; i < 2 * N; i++) begin
            step();
            send((i * 3 + 1) % N, 32'h7000_0000, 1'b0, w);
            check(c, "pushpop_ready", w == 0, 32'(w), 32'd0);
            check(c, "pushpop_out_valid", out_valid, 32'(out_valid), 32'd1);
         end
         step();
         in_valid = 1'b0;
         drain();

         // Reset while beats are in flight; a beat offered during reset is ignored.
         step();
         for (int i = 0; i < 3; i++) begin
            send(i % N, 32'h5000_0000, 1'b1, w);
            step();
         end
         present(N - 1, 32'hD000_0001);
         rst_n     = 1'b0;
         out_ready = 1'b0;
         step();
         rst_n     = 1'b1;
         in_valid  = 1'b0;
         out_ready = 1'b1;
         q.delete();
         @(negedge clk);
         check(c, "post_reset_out_valid", !out_valid, 32'(out_valid), 32'd0);
         check(c, "post_reset_out_data", out_data == '0, 32'(out_data), 32'd0);
         check(c, "post_reset_in_ready", in_ready, 32'(in_ready), 32'd1);
         repeat (LAT + 3) step();
         send(N - 1, 32'h6000_0000, 1'b1, w);
         check(c, "post_reset_accept", w == 0, 32'(w), 32'd0);
         step();
         in_valid = 1'b0;
         drain();
         done = 1'b1;
      end
   end

   initial begin
      int  n;
      bit  all_done;
      n        = 0;
      all_done = 1'b0;
      while (!all_done && n < 50000) begin
         @(posedge clk);
         n++;
         all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done;
      end
      check(0, "all_done", all_done, 32'(n), 32'd50000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
